pci_wr_capture: RTL and testbench

- Downstream consumer of the PCI data-path clock-enable (PCI_CE) in the PCI target.
- Tracks a memory-write burst after a decoded address phase and captures each completed data phase (IRDY_N and TRDY_N both low while PCI_CE=1).
- Each capture is a {address, data, byte-enable} word pushed into a small FWFT FIFO for the local CNC register side.
- Raises STOP_REQ toward the target FSM when the FIFO nears full, and flags dropped words.

---
 rtl/pci_wr_capture.sv | 177 +++++++++++++++++
 tb/tb_pci_wr_capture.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/pci_wr_capture.sv
// pci_wr_capture: follows a decoded PCI memory-write burst and captures each
// completed data phase as an {address, data, byte-enable} word into a small
// first-word-fall-through FIFO read by the local register side. It requests a
// target disconnect when the FIFO is nearly full and keeps a sticky flag for
// words dropped while full.
module pci_wr_capture #(
    parameter int DEPTH  = 8,
    parameter int AW     = 3,
    parameter int ADDR_W = 16
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic              PCI_CE,
    input  logic              ADDR_VLD,
    input  logic              WR_CMD,
    input  logic [ADDR_W-1:0] ADDR_IN,
    input  logic              FRAME_N,
    input  logic              IRDY_N,
    input  logic              TRDY_N,
    input  logic [31:0]       AD,
    input  logic [3:0]        CBE_N,
    input  logic              RD_EN,
    output logic [31:0]       DOUT_DATA,
    output logic [ADDR_W-1:0] DOUT_ADDR,
    output logic [3:0]        DOUT_BE,
    output logic              EMPTY,
    output logic              FULL,
    output logic [AW:0]       LEVEL,
    output logic              STOP_REQ,
    output logic              OVF,
    input  logic              OVF_CLR
);

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } state_t;

    localparam logic [AW:0] LVL_FULL = (AW+1)'(DEPTH);
    localparam logic [AW:0] LVL_STOP = (AW+1)'(DEPTH - 1);
    localparam logic [AW:0] LVL_ONE  = (AW+1)'(1);

    state_t            state;
    state_t            state_next;
    logic [ADDR_W-1:0] cur_addr;
    logic [ADDR_W-1:0] addr_next;
    logic [ADDR_W-1:0] addr_aligned;
    logic              phase_done;
    logic              push_req;

    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic [AW:0]       level;
    logic [AW:0]       level_next;
    logic              fifo_full;
    logic              fifo_empty;
    logic              pop_ok;
    logic              push_ok;
    logic              ovf_set;
    logic              ovf;
    logic              stop_req;

    logic [ADDR_W-1:0] mem_addr [DEPTH];
    logic [31:0]       mem_data [DEPTH];
    logic [3:0]        mem_be   [DEPTH];

    assign phase_done   = PCI_CE & ~IRDY_N & ~TRDY_N;
    assign addr_aligned = {ADDR_IN[ADDR_W-1:2], 2'b00};

    // Burst tracker next-state: address decode, capture requests, termination.
    always_comb begin
        // NOTE: every output of this block gets a default first so no path
        // leaves it unassigned, which would otherwise infer a latch.
        state_next = state;
        addr_next  = cur_addr;
        push_req   = 1'b0;
        case (state)
            IDLE: begin
                if (ADDR_VLD && WR_CMD) begin
                    state_next = BURST;
                    addr_next  = addr_aligned;
                end
            end
            BURST: begin
                if (ADDR_VLD) begin
                    // A new decoded address phase restarts the burst.
                    addr_next  = addr_aligned;
                    state_next = WR_CMD ? BURST : IDLE;
                end else if (phase_done) begin
                    push_req  = 1'b1;
                    addr_next = cur_addr + ADDR_W'(4);
                    if (FRAME_N) begin
                        state_next = IDLE;
                    end
                end else if (FRAME_N && IRDY_N) begin
                    // Bus went idle without a final data phase.
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Burst tracker state and running byte address.
    always_ff @(posedge CLK or negedge RST_N) begin
        // NOTE: state registers use non-blocking assignments so every flop
        // samples the pre-edge values regardless of statement order.
        if (!RST_N) begin
            state    <= IDLE;
            cur_addr <= '0;
        end else begin
            state    <= state_next;
            cur_addr <= addr_next;
        end
    end

    // FIFO handshake: a pop frees room for a same-cycle push when full,
    // and a pop against an empty FIFO is simply ignored.
    always_comb begin
        fifo_full  = (level == LVL_FULL);
        fifo_empty = (level == '0);
        pop_ok     = RD_EN & ~fifo_empty;
        push_ok    = push_req & (~fifo_full | pop_ok);
        ovf_set    = push_req & fifo_full & ~pop_ok;
        case ({push_ok, pop_ok})
            2'b10:   level_next = level + LVL_ONE;
            2'b01:   level_next = level - LVL_ONE;
            default: level_next = level;
        endcase
    end

    // FIFO pointers, occupancy, sticky overflow and the disconnect request.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            level    <= '0;
            ovf      <= 1'b0;
            stop_req <= 1'b0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            level <= level_next;
            if (ovf_set) begin
                ovf <= 1'b1;
            end else if (OVF_CLR) begin
                ovf <= 1'b0;
            end
            stop_req <= (state_next == BURST) && (level_next >= LVL_STOP);
        end
    end

    // FIFO storage write port.
    always_ff @(posedge CLK) begin
        // NOTE: storage is deliberately not reset; the pointers and level
        // define which entries are valid, and the outputs are masked when empty.
        if (push_ok) begin
            mem_addr[wr_ptr] <= cur_addr;
            mem_data[wr_ptr] <= AD;
            mem_be[wr_ptr]   <= ~CBE_N;
        end
    end

    assign DOUT_ADDR = fifo_empty ? '0 : mem_addr[rd_ptr];
    assign DOUT_DATA = fifo_empty ? '0 : mem_data[rd_ptr];
    assign DOUT_BE   = fifo_empty ? '0 : mem_be[rd_ptr];
    assign EMPTY     = fifo_empty;
    assign FULL      = fifo_full;
    assign LEVEL     = level;
    assign OVF       = ovf;
    assign STOP_REQ  = stop_req;

endmodule

// File: tb/tb_pci_wr_capture.sv
// Testbench for pci_wr_capture: directed PCI write bursts. Expected FIFO words
// are queued as each data phase is driven; a monitor compares the FIFO head
// against the queue whenever the bench pops a non-empty FIFO.
module tb_pci_wr_capture;

    logic        CLK;
    logic        RST_N;
    logic        PCI_CE;
    logic        ADDR_VLD;
    logic        WR_CMD;
    logic [15:0] ADDR_IN;
    logic        FRAME_N;
    logic        IRDY_N;
    logic        TRDY_N;
    logic [31:0] AD;
    logic [3:0]  CBE_N;
    logic        RD_EN;
    logic [31:0] DOUT_DATA;
    logic [15:0] DOUT_ADDR;
    logic [3:0]  DOUT_BE;
    logic        EMPTY;
    logic        FULL;
    logic [3:0]  LEVEL;
    logic        STOP_REQ;
    logic        OVF;
    logic        OVF_CLR;

    int n_checks = 0;
    int n_pass   = 0;

    // Expected words: {addr[15:0], data[31:0], be[3:0]}.
    logic [51:0] sb[$];

    pci_wr_capture #(.DEPTH(8), .AW(3), .ADDR_W(16)) dut (
        .CLK(CLK), .RST_N(RST_N), .PCI_CE(PCI_CE), .ADDR_VLD(ADDR_VLD),
        .WR_CMD(WR_CMD), .ADDR_IN(ADDR_IN), .FRAME_N(FRAME_N),
        .IRDY_N(IRDY_N), .TRDY_N(TRDY_N), .AD(AD), .CBE_N(CBE_N),
        .RD_EN(RD_EN), .DOUT_DATA(DOUT_DATA), .DOUT_ADDR(DOUT_ADDR),
        .DOUT_BE(DOUT_BE), .EMPTY(EMPTY), .FULL(FULL), .LEVEL(LEVEL),
        .STOP_REQ(STOP_REQ), .OVF(OVF), .OVF_CLR(OVF_CLR)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end else begin
            n_pass++;
        end
    endtask

    // Advance one clock; inputs change and flags are sampled 1 time unit after the edge.
    task automatic cyc();
        @(posedge CLK);
        #1;
    endtask

    task automatic addr_phase(input logic [15:0] addr, input logic wr);
        ADDR_VLD = 1'b1;
        WR_CMD   = wr;
        ADDR_IN  = addr;
        FRAME_N  = 1'b0;
        cyc();
        ADDR_VLD = 1'b0;
        WR_CMD   = 1'b0;
    endtask

    task automatic data_phase(input logic [31:0] ad, input logic [3:0] cbe_n, input logic last,
                              input logic cap, input logic [15:0] exp_addr);
        if (cap) sb.push_back({exp_addr, ad, ~cbe_n});
        IRDY_N  = 1'b0;
        TRDY_N  = 1'b0;
        FRAME_N = last;
        AD      = ad;
        CBE_N   = cbe_n;
        cyc();
        IRDY_N  = 1'b1;
        TRDY_N  = 1'b1;
        FRAME_N = last;
    endtask

    task automatic drain(input int n);
        RD_EN = 1'b1;
        repeat (n) cyc();
        RD_EN = 1'b0;
    endtask

    // Monitor: whenever a pop of a non-empty FIFO is about to happen, the head must match.
    initial begin
        logic [51:0] exp;
        forever begin
            @(negedge CLK);
            if (RST_N && RD_EN && !EMPTY) begin
                if (sb.size() == 0) begin
                    check("sb_unexpected_word", {DOUT_ADDR, DOUT_DATA, DOUT_BE}, 64'h0);
                end else begin
                    exp = sb.pop_front();
                    check("dout_head", {DOUT_ADDR, DOUT_DATA, DOUT_BE}, exp);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        RST_N = 1'b0; PCI_CE = 1'b1; ADDR_VLD = 1'b0; WR_CMD = 1'b0; ADDR_IN = '0;
        FRAME_N = 1'b1; IRDY_N = 1'b1; TRDY_N = 1'b1; AD = '0; CBE_N = 4'hF;
        RD_EN = 1'b0; OVF_CLR = 1'b0;
        repeat (2) cyc();

        // Reset state
        check("rst_empty", EMPTY, 1);
        check("rst_full", FULL, 0);
        check("rst_level", LEVEL, 0);
        check("rst_stop", STOP_REQ, 0);
        check("rst_ovf", OVF, 0);
        check("rst_dout", {DOUT_ADDR, DOUT_DATA, DOUT_BE}, 64'h0);
        RST_N = 1'b1;
        cyc();

        // Single write
        addr_phase(16'h0104, 1'b1);
        data_phase(32'hDEADBEEF, 4'h0, 1'b1, 1'b1, 16'h0104);
        check("single_empty", EMPTY, 0);
        check("single_addr", DOUT_ADDR, 16'h0104);
        check("single_data", DOUT_DATA, 32'hDEADBEEF);
        check("single_be", DOUT_BE, 4'hF);
        // Back in IDLE: a stray completed phase is not captured
        data_phase(32'h0BAD0BAD, 4'h0, 1'b1, 1'b0, 16'h0000);
        check("single_idle_level", LEVEL, 1);
        drain(1);
        check("single_drained", EMPTY, 1);

        // Burst with wait states, a PCI_CE-low cycle and address wrap
        addr_phase(16'hFFF8, 1'b1);
        data_phase(32'h1111_0001, 4'h0, 1'b0, 1'b1, 16'hFFF8);
        IRDY_N = 1'b0; TRDY_N = 1'b1; cyc();
        TRDY_N = 1'b0; PCI_CE = 1'b0; AD = 32'hBAD0BAD0; cyc();
        PCI_CE = 1'b1; IRDY_N = 1'b1; TRDY_N = 1'b1;
        data_phase(32'h2222_0002, 4'h3, 1'b0, 1'b1, 16'hFFFC);
        IRDY_N = 1'b0; cyc(); IRDY_N = 1'b1;
        data_phase(32'h3333_0003, 4'hA, 1'b0, 1'b1, 16'h0000);
        data_phase(32'h4444_0004, 4'hF, 1'b1, 1'b1, 16'h0004);
        check("burst_level", LEVEL, 4);
        drain(4);
        check("burst_drained", EMPTY, 1);

        // Back-pressure: fill 8 entries, STOP_REQ from level 7
        addr_phase(16'h0200, 1'b1);
        for (int i = 0; i < 8; i++) begin
            data_phase(32'hA000_0000 + i, 4'(i), 1'b0, 1'b1, 16'h0200 + 16'(i * 4));
            check("bp_stop", STOP_REQ, (i + 1 >= 7) ? 1 : 0);
        end
        check("bp_full", FULL, 1);
        check("bp_level8", LEVEL, 8);
        // 9th word dropped (address 0x0220)
        data_phase(32'hDD00_0009, 4'h0, 1'b0, 1'b0, 16'h0220);
        check("ovf_set", OVF, 1);
        check("ovf_level", LEVEL, 8);
        check("ovf_stop", STOP_REQ, 1);
        // Overflow together with OVF_CLR: set wins (address 0x0224 dropped)
        OVF_CLR = 1'b1;
        data_phase(32'hDD00_000A, 4'h0, 1'b0, 1'b0, 16'h0224);
        OVF_CLR = 1'b0;
        check("ovf_set_wins", OVF, 1);
        OVF_CLR = 1'b1; cyc(); OVF_CLR = 1'b0;
        check("ovf_clr", OVF, 0);
        // Full with simultaneous push and pop
        RD_EN = 1'b1;
        data_phase(32'hC0DE_0000, 4'h5, 1'b0, 1'b1, 16'h0228);
        RD_EN = 1'b0;
        check("pp_level", LEVEL, 8);
        check("pp_ovf", OVF, 0);
        check("pp_new_head", DOUT_ADDR, 16'h0204);
        // Abort: bus idle with no final phase
        FRAME_N = 1'b1; IRDY_N = 1'b1; cyc();
        check("abort_stop", STOP_REQ, 0);
        check("abort_level", LEVEL, 8);
        data_phase(32'h0BAD0BAD, 4'h0, 1'b1, 1'b0, 16'h0000);
        check("abort_idle_level", LEVEL, 8);
        drain(8);
        check("bp_drained", EMPTY, 1);

        // Non-write address phase: following phase ignored
        addr_phase(16'h0300, 1'b0);
        data_phase(32'h5555_5555, 4'h0, 1'b1, 1'b0, 16'h0000);
        check("nonwr_level", LEVEL, 0);
        check("nonwr_empty", EMPTY, 1);

        // Asynchronous reset mid-burst
        addr_phase(16'h0400, 1'b1);
        data_phase(32'h6000_0001, 4'h0, 1'b0, 1'b0, 16'h0400);
        data_phase(32'h6000_0002, 4'h0, 1'b0, 1'b0, 16'h0404);
        data_phase(32'h6000_0003, 4'h0, 1'b0, 1'b0, 16'h0408);
        check("arst_pre_level", LEVEL, 3);
        #2;
        RST_N = 1'b0;
        #1;
        check("arst_empty", EMPTY, 1);
        check("arst_level", LEVEL, 0);
        check("arst_stop", STOP_REQ, 0);
        check("arst_ovf", OVF, 0);
        cyc();
        RST_N = 1'b1;
        data_phase(32'h7777_7777, 4'h0, 1'b0, 1'b0, 16'h0000);
        check("arst_ignored", LEVEL, 0);
        FRAME_N = 1'b1; cyc();
        addr_phase(16'h0502, 1'b1);
        data_phase(32'h8888_0001, 4'h6, 1'b1, 1'b1, 16'h0500);
        check("post_rst_level", LEVEL, 1);
        drain(1);

        check("sb_drained", 64'(sb.size()), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
